// File: rtl/par2serial_pkg.sv
// par2serial shared constants: comma byte, FSM state encoding, bit counter width.
// Also used by the serialtopar receiver and its checker.
package par2serial_pkg;

  localparam logic [7:0] COMMA_BYTE = 8'hBC;
  localparam int         BIT_CNT_W  = 3;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/par2serial_tx.sv
// par2serial_tx: byte to MSB-first serial transmitter with 0xBC comma sync/idle.
// Ports: clk_8f, reset_L (async low), data_in[7:0], valid_in -> ready_out,
//        data_out, active_out. Optional macro COMMA_INSERT_EN forces a comma
//        after COMMA_PERIOD back-to-back data bytes.
module par2serial_tx
  import par2serial_pkg::*;
#(
  parameter int SYNC_COUNT   = 4,
  parameter int COMMA_PERIOD = 16
) (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active_out
);

  if (SYNC_COUNT < 1 || SYNC_COUNT > 15) begin : g_bad_sync
    $error("par2serial_tx: SYNC_COUNT must be 1..15");
  end
  if (COMMA_PERIOD < 1 || COMMA_PERIOD > 255) begin : g_bad_period
    $error("par2serial_tx: COMMA_PERIOD must be 1..255");
  end

  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = '1;
  localparam logic [3:0]           SYNC_LAST = 4'(SYNC_COUNT);

  logic [7:0]           shreg_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  state_e               state_q;
  logic [3:0]           sync_cnt_q;
  logic                 boundary;
  logic                 force_comma;
  logic                 xfer;

`ifdef COMMA_INSERT_EN
  localparam logic [7:0] RUN_LAST = 8'(COMMA_PERIOD);
  logic [7:0] run_cnt_q;
  assign force_comma = (run_cnt_q == RUN_LAST);
`else
  assign force_comma = 1'b0;
`endif

  assign boundary = (bit_cnt_q == BIT_LAST);

  // The sync phase's last boundary already accepts data, so ready
  // opens when sync_cnt reaches SYNC_COUNT, before state turns ACTIVE.
  assign ready_out = boundary
                   && (state_q == ACTIVE || sync_cnt_q == SYNC_LAST)
                   && !force_comma;

  assign xfer       = valid_in && ready_out;
  assign data_out   = shreg_q[7];
  assign active_out = (state_q == ACTIVE);

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      shreg_q    <= '0;
      bit_cnt_q  <= BIT_LAST;
      state_q    <= SYNC;
      sync_cnt_q <= '0;
`ifdef COMMA_INSERT_EN
      run_cnt_q  <= '0;
`endif
    end else if (boundary) begin
      bit_cnt_q <= '0;
      shreg_q   <= xfer ? data_in : COMMA_BYTE;
      if (state_q == SYNC) begin
        if (sync_cnt_q != SYNC_LAST) begin
          sync_cnt_q <= sync_cnt_q + 4'd1;
        end else begin
          state_q <= ACTIVE;
        end
      end
`ifdef COMMA_INSERT_EN
      run_cnt_q <= xfer ? run_cnt_q + 8'd1 : 8'd0;
`endif
    end else begin
      shreg_q   <= {shreg_q[6:0], 1'b0};
      bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_par2serial_tx.sv
// tb_par2serial_tx: table vectors, hand sequences and random stimulus
// checked bit-by-bit against an edge-count/byte-queue reference model.
module tb_par2serial_tx;

  localparam int SC = 4;
`ifdef COMMA_INSERT_EN
  localparam int CP = 2;
`else
  localparam int CP = 16;
`endif

  logic       clk = 1'b0;
  logic       reset_L = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       data_out;
  logic       active_out;

  int checks = 0;
  int failures = 0;

  // reference model: edges since reset release, bytes loaded so far,
  // consecutive data bytes, and the bits still to appear on the line
  int   edge_k;
  int   bytes_done;
  int   run;
  logic bitq[$];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[6];

  par2serial_tx #(
    .SYNC_COUNT  (SC),
    .COMMA_PERIOD(CP)
  ) dut (
    .clk_8f    (clk),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .active_out(active_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    edge_k     = 0;
    bytes_done = 0;
    run        = 0;
    bitq.delete();
  endtask

  task automatic tick();
    logic       bnd;
    logic       frc;
    logic       rdy;
    logic [7:0] b;
    logic       e;
    bnd = (edge_k % 8 == 0);
`ifdef COMMA_INSERT_EN
    frc = (run == CP);
`else
    frc = 1'b0;
`endif
    rdy = bnd && (bytes_done >= SC) && !frc;
    chk("ready_out", {7'd0, ready_out}, {7'd0, rdy});
    if (bnd) begin
      if (rdy && valid_in) begin
        b = data_in;
        run++;
      end else begin
        b = 8'hBC;
        run = 0;
      end
      bytes_done++;
      bitq.delete();
      for (int i = 7; i >= 0; i--) bitq.push_back(b[i]);
    end
    @(posedge clk);
    #1;
    edge_k++;
    e = bitq.pop_front();
    chk("data_out", {7'd0, data_out}, {7'd0, e});
    chk("active_out", {7'd0, active_out},
        {7'd0, (bytes_done > SC) ? 1'b1 : 1'b0});
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    #1;
    chk("rst_data_out", {7'd0, data_out}, 8'd0);
    chk("rst_active", {7'd0, active_out}, 8'd0);
    chk("rst_ready", {7'd0, ready_out}, 8'd0);
    #12;
    @(negedge clk);
    reset_L = 1'b1;
    model_reset();
  endtask

  task automatic get_byte(output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      got = {got[6:0], data_out};
    end
  endtask

  initial begin
    logic [7:0] got;

`ifdef COMMA_INSERT_EN
    tbl[0] = '{1'b1, 8'h55, 8'h55};
    tbl[1] = '{1'b1, 8'h55, 8'h55};
    tbl[2] = '{1'b1, 8'h55, 8'hBC};
    tbl[3] = '{1'b1, 8'h55, 8'h55};
    tbl[4] = '{1'b1, 8'h55, 8'h55};
    tbl[5] = '{1'b1, 8'h55, 8'hBC};
`else
    tbl[0] = '{1'b1, 8'hFF, 8'hFF};
    tbl[1] = '{1'b1, 8'hEE, 8'hEE};
    tbl[2] = '{1'b1, 8'hDD, 8'hDD};
    tbl[3] = '{1'b0, 8'h12, 8'hBC};
    tbl[4] = '{1'b1, 8'hBC, 8'hBC};
    tbl[5] = '{1'b1, 8'h00, 8'h00};
`endif

    #2;
    do_reset();

    // sync phase: four commas, active only after the fifth boundary
    for (int n = 0; n < SC; n++) begin
      get_byte(got);
      chk("sync_comma", got, 8'hBC);
    end
    chk("active_pre", {7'd0, active_out}, 8'd0);

    // table: inputs held over a byte; data_in scrambled after capture
    for (int r = 0; r < 6; r++) begin
      valid_in = tbl[r].v;
      data_in  = tbl[r].d;
      got = 8'h00;
      for (int i = 0; i < 8; i++) begin
        tick();
        got = {got[6:0], data_out};
        data_in = ~tbl[r].d;
      end
      chk("tbl_byte", got, tbl[r].exp);
    end
    valid_in = 1'b0;
    get_byte(got);
    chk("idle_comma", got, 8'hBC);

    // randomized traffic, data_in changes every cycle
    for (int n = 0; n < 600; n++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      data_in  = 8'($urandom);
      tick();
    end

    // reset in the middle of 0xEE
    valid_in = 1'b0;
    do_reset();
    repeat (8 * SC) tick();
    valid_in = 1'b1;
    data_in  = 8'hEE;
    tick();
    valid_in = 1'b0;
    repeat (3) tick();
    do_reset();

    // valid held high through sync: no transfer before the sync ends
    valid_in = 1'b1;
    data_in  = 8'h3C;
    for (int n = 0; n < SC; n++) begin
      get_byte(got);
      chk("sync_valid_hi", got, 8'hBC);
    end
    get_byte(got);
    chk("first_data", got, 8'h3C);
    valid_in = 1'b0;
    get_byte(got);
    get_byte(got);
    chk("idle_after", got, 8'hBC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
